fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch controller: reads the program counter register value, fetches from a
//  synchronous instruction memory, holds the word for decode under a valid/ready handshake,
//  then computes and writes back the next PC (pc_next + wpc_en) for the PC register to load.
//  Sits between the PC register, the instruction ROM and the decoder; one instruction in flight.
// PARAMETERS
//  PC_W      12  width of PC / imem address
//  INSTR_W   9   instruction word width
//  IMEM_LAT  1   imem read latency in clocks (1..4)
//  CNT_W     16  width of retired-instruction counter
// PORTS
//  clk             in   1        clock, all state on rising edge
//  reset           in   1        asynchronous, active-high
//  pc_in           in   PC_W     current PC register value
//  pc_next         out  PC_W     value for PC register to load
//  wpc_en          out  1        PC register write enable, 1-cycle pulse
//  imem_addr       out  PC_W     instruction memory address
//  imem_rdata      in   INSTR_W  instruction memory read data
//  instr           out  INSTR_W  fetched instruction to decode
//  instr_valid     out  1        instr is valid
//  instr_ready     in   1        decode accepts instr
//  redirect_valid  in   1        taken branch/jump, sampled only on accept cycle
//  redirect_target in   PC_W     branch/jump target
//  halt            in   1        accepted instruction is the done/halt op
//  done            out  1        program halted (sticky until reset)
//  retired         out  CNT_W    count of accepted instructions, saturating
// BEHAVIOUR
//  Reset (async): state=ISSUE, wpc_en=0, pc_next=0, instr=0, instr_valid=0, done=0, retired=0.
//  imem_addr = pc_in combinationally; pc_in only changes after a wpc_en pulse, so stable in flight.
//  States: ISSUE -> WAIT -> VALID -> ISSUE; any -> HALTED only from VALID.
//   ISSUE : 1 cycle; load latency counter with IMEM_LAT; -> WAIT.
//   WAIT  : IMEM_LAT cycles; on final WAIT edge capture imem_rdata into instr; -> VALID.
//   VALID : instr_valid=1, instr held constant until accept (instr_valid & instr_ready).
//           on accept: retired+=1 (saturate at all-ones); then
//            halt=1           -> HALTED, no wpc_en, done=1 next cycle (halt wins over redirect);
//            redirect_valid=1 -> pc_next=redirect_target, wpc_en=1 for one cycle, -> ISSUE;
//            else             -> pc_next=pc_in+1 mod 2^PC_W (0xFFF wraps to 0x000), wpc_en=1, -> ISSUE.
//           no accept: stay; redirect_valid/halt ignored.
//   HALTED: instr_valid=0, wpc_en=0, done=1; exit only via reset.
//  pc_next and wpc_en are registered: asserted in cycle after accept; PC loads at that cycle's end.
//  Throughput: next instr_valid rises IMEM_LAT+3 cycles after accept cycle (wpc, ISSUE, WAIT x LAT).
//  instr_valid never drops without accept; instr_ready while instr_valid=0 has no effect.
//  Reset mid-fetch or mid-handshake: discard in-flight word, return to reset values immediately.
// STRUCTURE
//  Shared package fetch_pkg: fetch_state_t enum {ISSUE, WAIT, VALID, HALTED}, PC_W/INSTR_W
//  constants. Single module; latency counter is a small local down-counter, no sub-module.
// TESTING
//  1 reset, ROM[0..2]=9'h011,9'h022,9'h033, ready=1: instr 011,022,033 in order; pc_next 1,2,3;
//    one wpc_en pulse per instr; IMEM_LAT=1 -> valid rises every 4 cycles.
//  2 backpressure: ready=0 for 5 cycles in VALID: instr stable, instr_valid=1, no wpc_en, retired flat.
//  3 redirect: at PC=5 accept with redirect_valid=1, target=12'h0A0 -> pc_next=0x0A0; next imem_addr=0x0A0;
//    redirect_valid=1 while ready=0 -> ignored.
//  4 wrap: pc_in=0xFFF accept, no redirect -> pc_next=0x000; halt+redirect same accept -> done=1, no wpc_en.
//  5 IMEM_LAT=3: valid-to-valid spacing 6 cycles; instr matches ROM at addr of each fetch.
//  6 reset asserted in WAIT and in VALID: outputs at reset values same cycle; refetch from PC 0 after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch controller.
package fetch_pkg;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 9;

    typedef enum logic [1:0] {
        ISSUE,
        WAIT,
        VALID,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: one fetch in flight, valid/ready hand-off to decode,
// registered next-PC write-back, sticky halt and a saturating retired counter.
module fetch_ctrl #(
    parameter int PC_W     = fetch_pkg::PC_W,
    parameter int INSTR_W  = fetch_pkg::INSTR_W,
    parameter int IMEM_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc_in,
    output logic [PC_W-1:0]    pc_next,
    output logic               wpc_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_target,
    input  logic               halt,
    output logic               done,
    output logic [CNT_W-1:0]   retired
);

    import fetch_pkg::*;

    localparam int LAT_W = 3;

    fetch_state_t     state;
    logic [LAT_W-1:0] lat_cnt;
    logic             accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + {{(PC_W-1){1'b0}}, 1'b1};
    endfunction

    // PC register only moves after a wpc_en pulse, so the address is stable in flight.
    assign imem_addr = pc_in;
    assign accept    = instr_valid && instr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ISSUE;
            lat_cnt     <= '0;
            wpc_en      <= 1'b0;
            pc_next     <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
            retired     <= '0;
        end else begin
            wpc_en <= 1'b0;
            case (state)
                ISSUE: begin
                    // While the write-back pulse is out, pc_in still holds the old PC.
                    if (!wpc_en) begin
                        lat_cnt <= LAT_W'(IMEM_LAT);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt <= LAT_W'(1)) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= VALID;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                VALID: begin
                    if (accept) begin
                        instr_valid <= 1'b0;
                        retired     <= sat_inc(retired);
                        if (halt) begin
                            done  <= 1'b1;
                            state <= HALTED;
                        end else begin
                            wpc_en  <= 1'b1;
                            pc_next <= redirect_valid ? redirect_target : pc_inc(pc_in);
                            state   <= ISSUE;
                        end
                    end
                end
                HALTED: begin
                    instr_valid <= 1'b0;
                    done        <= 1'b1;
                end
                default: state <= ISSUE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a 1-cycle-latency instance exercises the handshake,
// redirect, wrap, halt and reset paths; a 3-cycle-latency instance checks fetch spacing.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;

    logic [11:0] pc_a, pc_next_a, imem_addr_a;
    logic        wpc_en_a;
    logic [8:0]  rdata_a, instr_a;
    logic        instr_valid_a, instr_ready;
    logic        redirect_valid;
    logic [11:0] redirect_target;
    logic        halt;
    logic        done_a;
    logic [15:0] retired_a;

    logic [11:0] pc_b, pc_next_b, imem_addr_b;
    logic        wpc_en_b;
    logic [8:0]  rdata_b, rom_p1_b, rom_p2_b, instr_b;
    logic        instr_valid_b, ready_b;
    logic        done_b;
    logic [15:0] retired_b;

    logic [8:0]  rom [0:4095];

    int n_checks;
    int n_pass;
    int exp_retired;

    fetch_ctrl #(.PC_W(12), .INSTR_W(9), .IMEM_LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .pc_in(pc_a), .pc_next(pc_next_a), .wpc_en(wpc_en_a),
        .imem_addr(imem_addr_a), .imem_rdata(rdata_a), .instr(instr_a),
        .instr_valid(instr_valid_a), .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halt(halt), .done(done_a), .retired(retired_a)
    );

    fetch_ctrl #(.PC_W(12), .INSTR_W(9), .IMEM_LAT(3), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .pc_in(pc_b), .pc_next(pc_next_b), .wpc_en(wpc_en_b),
        .imem_addr(imem_addr_b), .imem_rdata(rdata_b), .instr(instr_b),
        .instr_valid(instr_valid_b), .instr_ready(ready_b),
        .redirect_valid(1'b0), .redirect_target(12'h000),
        .halt(1'b0), .done(done_b), .retired(retired_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC registers and synchronous ROMs around each instance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_a <= '0;
            pc_b <= '0;
        end else begin
            if (wpc_en_a) pc_a <= pc_next_a;
            if (wpc_en_b) pc_b <= pc_next_b;
        end
    end

    always_ff @(posedge clk) begin
        rdata_a  <= rom[imem_addr_a];
        rom_p1_b <= rom[imem_addr_b];
        rom_p2_b <= rom_p1_b;
        rdata_b  <= rom_p2_b;
    end

    function automatic logic [8:0] rom_val(input int a);
        case (a)
            0:       return 9'h011;
            1:       return 9'h022;
            2:       return 9'h033;
            default: return 9'((a * 7 + 3) & 'h1FF);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"},   instr_valid_a, 1'b0);
        check({tag, "_wpc"},     wpc_en_a,      1'b0);
        check({tag, "_pcnext"},  pc_next_a,     12'h000);
        check({tag, "_instr"},   instr_a,       9'h000);
        check({tag, "_done"},    done_a,        1'b0);
        check({tag, "_retired"}, retired_a,     16'd0);
    endtask

    task automatic wait_valid(output int ticks, output int wpcs);
        ticks = 0;
        wpcs  = 0;
        while (!instr_valid_a && ticks < 50) begin
            tick();
            ticks++;
            if (wpc_en_a) wpcs++;
        end
        check("valid_rise", instr_valid_a, 1'b1);
    endtask

    task automatic accept(input bit redir, input logic [11:0] tgt, input bit hlt,
                          input logic [11:0] exp_pc);
        redirect_valid  = redir;
        redirect_target = tgt;
        halt            = hlt;
        instr_ready     = 1'b1;
        tick();
        instr_ready     = 1'b0;
        redirect_valid  = 1'b0;
        halt            = 1'b0;
        exp_retired++;
        if (hlt) begin
            check("halt_wpc",   wpc_en_a,      1'b0);
            check("halt_done",  done_a,        1'b1);
            check("halt_valid", instr_valid_a, 1'b0);
        end else begin
            check("acc_wpc",    wpc_en_a,  1'b1);
            check("acc_pcnext", pc_next_a, exp_pc);
        end
        check("acc_retired", retired_a, exp_retired);
    endtask

    initial begin
        int t, w, bad_wpc, bad_valid, bad_done;
        n_checks        = 0;
        n_pass          = 0;
        exp_retired     = 0;
        reset           = 1'b1;
        instr_ready     = 1'b0;
        ready_b         = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 12'h000;
        halt            = 1'b0;
        for (int i = 0; i < 4096; i++) rom[i] = rom_val(i);

        tick();
        tick();
        check_reset_vals("rst");
        reset = 1'b0;

        // In-order fetch of the first three words with ready asserted on sight
        wait_valid(t, w);
        check("first_instr", instr_a, 9'h011);
        check("first_addr",  imem_addr_a, 12'h000);
        for (int k = 0; k < 3; k++) begin
            accept(1'b0, 12'h000, 1'b0, 12'(k + 1));
            wait_valid(t, w);
            check("spacing_lat1", 32'(t + 1), 32'd4);
            check("one_wpc",      32'(w), 32'd0);
            check("instr_seq",    instr_a, rom_val(k + 1));
        end

        // Backpressure at PC 3 with a redirect that must be ignored
        redirect_valid  = 1'b1;
        redirect_target = 12'h0A0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_instr",   instr_a,       rom_val(3));
            check("bp_valid",   instr_valid_a, 1'b1);
            check("bp_wpc",     wpc_en_a,      1'b0);
            check("bp_retired", retired_a,     16'd3);
        end
        redirect_valid = 1'b0;
        accept(1'b0, 12'h000, 1'b0, 12'h004);
        wait_valid(t, w);
        accept(1'b0, 12'h000, 1'b0, 12'h005);
        wait_valid(t, w);
        check("pc5_addr", imem_addr_a, 12'h005);

        // Redirect from PC 5, then jump to the top of the address space
        accept(1'b1, 12'h0A0, 1'b0, 12'h0A0);
        wait_valid(t, w);
        check("redir_addr",  imem_addr_a, 12'h0A0);
        check("redir_instr", instr_a,     rom_val('h0A0));
        accept(1'b1, 12'hFFF, 1'b0, 12'hFFF);
        wait_valid(t, w);
        check("top_addr",  imem_addr_a, 12'hFFF);
        check("top_instr", instr_a,     rom_val('hFFF));
        accept(1'b0, 12'h000, 1'b0, 12'h000);
        wait_valid(t, w);
        check("wrap_addr",  imem_addr_a, 12'h000);
        check("wrap_instr", instr_a,     9'h011);

        // Halt and redirect on the same accept: halt wins
        accept(1'b1, 12'h123, 1'b1, 12'h000);
        bad_wpc   = 0;
        bad_valid = 0;
        bad_done  = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (wpc_en_a)      bad_wpc++;
            if (instr_valid_a) bad_valid++;
            if (!done_a)       bad_done++;
        end
        check("halted_wpc",    32'(bad_wpc),   32'd0);
        check("halted_valid",  32'(bad_valid), 32'd0);
        check("halted_done",   32'(bad_done),  32'd0);
        check("halted_pcnext", pc_next_a,      12'h000);

        // Three-cycle memory latency: six cycles valid to valid
        ready_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("lat3_valid", instr_valid_b, 1'b1);
            check("lat3_instr", instr_b,       rom_val(k));
            check("lat3_addr",  imem_addr_b,   12'(k));
            tick();
            t = 1;
            while (!instr_valid_b && t < 50) begin
                tick();
                t++;
            end
            check("spacing_lat3", 32'(t), 32'd6);
        end
        ready_b = 1'b0;

        // Asynchronous reset out of HALTED, in WAIT and in VALID
        #2 reset = 1'b1;
        #1 check_reset_vals("rst_halted");
        reset       = 1'b0;
        exp_retired = 0;
        tick();
        #2 reset = 1'b1;
        #1 check_reset_vals("rst_wait");
        reset = 1'b0;
        wait_valid(t, w);
        check("refetch_instr", instr_a,     9'h011);
        check("refetch_addr",  imem_addr_a, 12'h000);
        #2 reset = 1'b1;
        #1 check_reset_vals("rst_valid");
        reset = 1'b0;
        wait_valid(t, w);
        check("refetch2_instr", instr_a, 9'h011);
        accept(1'b0, 12'h000, 1'b0, 12'h001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
